repetition_matcher: RTL and testbench

Multi-channel RTL repetition detector: each channel recognises either a consecutive repetition of its event (ev high N cycles in a row, `ev[*N]`) or a goto repetition after a trigger (`start ##1 ev[->N]`). Each channel has a runtime count and an optional timeout. It sits beside the design as a synthesizable monitor. Its match and timeout pulses feed cover/assert logic, scoreboards, or interrupt aggregation, so formal and simulation flows count the same repetitions.

---
 rtl/rep_pkg.sv | 21 ++
 rtl/rep_channel.sv | 152 +++++++++++++++
 rtl/repetition_matcher.sv | 45 ++++
 tb/tb_repetition_matcher.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rep_pkg.sv
// Shared types and helpers for the repetition matcher.
package rep_pkg;

    // Per-channel recognition mode.
    typedef enum logic {
        REP_CONSEC = 1'b0,
        REP_GOTO   = 1'b1
    } rep_mode_e;

    // Goto-window state.
    typedef enum logic {
        REP_IDLE  = 1'b0,
        REP_ARMED = 1'b1
    } rep_state_e;

    // Width needed to hold any count from 0 to max_count inclusive.
    function automatic int rep_cw(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/rep_channel.sv
// One repetition-matcher channel: consecutive run counter plus goto window FSM.
module rep_channel
    import rep_pkg::*;
#(
    parameter int CW = 4,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_ev,
    input  logic          i_start,
    input  logic          i_mode,
    input  logic [CW-1:0] i_count,
    input  logic [TW-1:0] i_timeout,
    output logic          o_match,
    output logic          o_timeout,
    output logic          o_busy
);

    rep_state_e    r_state,  w_state_nx;
    rep_mode_e     r_mode;
    rep_mode_e     w_mode;
    logic [CW-1:0] r_run,    w_run_nx;
    logic [CW-1:0] r_hits,   w_hits_nx;
    logic [CW-1:0] r_target, w_target_nx;
    logic [TW-1:0] r_wait,   w_wait_nx;
    logic          r_match,  w_match_nx;
    logic          r_timeout, w_timeout_nx;

    logic [CW:0]   w_run_inc;
    logic [CW:0]   w_hits_inc;
    logic [TW:0]   w_wait_inc;
    logic [TW-1:0] w_wait_sat;
    logic          w_hit_done;
    logic          w_expire;

    assign w_mode     = rep_mode_e'(i_mode);
    // One bit of headroom so run+1 / hits+1 / wait+1 never wrap in the compares.
    assign w_run_inc  = {1'b0, r_run} + (CW+1)'(1);
    assign w_hits_inc = {1'b0, r_hits} + (CW+1)'(1);
    assign w_wait_inc = {1'b0, r_wait} + (TW+1)'(1);
    assign w_wait_sat = (&r_wait) ? r_wait : w_wait_inc[TW-1:0];
    assign w_hit_done = i_ev && (w_hits_inc == {1'b0, r_target});
    assign w_expire   = (i_timeout != '0) && (w_wait_inc == {1'b0, i_timeout});

    // State register and all counters; outputs are these registers directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= REP_IDLE;
            r_mode    <= REP_CONSEC;
            r_run     <= '0;
            r_hits    <= '0;
            r_target  <= '0;
            r_wait    <= '0;
            r_match   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_mode    <= w_mode;
            r_run     <= w_run_nx;
            r_hits    <= w_hits_nx;
            r_target  <= w_target_nx;
            r_wait    <= w_wait_nx;
            r_match   <= w_match_nx;
            r_timeout <= w_timeout_nx;
        end
    end

    // Next-state, counter updates and pulse generation.
    always_comb begin
        w_state_nx   = r_state;
        w_run_nx     = r_run;
        w_hits_nx    = r_hits;
        w_target_nx  = r_target;
        w_wait_nx    = r_wait;
        w_match_nx   = 1'b0;
        w_timeout_nx = 1'b0;

        if ((i_count == '0) || (w_mode != r_mode)) begin
            // Disabled channel or mode switch: drop everything silently.
            w_state_nx  = REP_IDLE;
            w_run_nx    = '0;
            w_hits_nx   = '0;
            w_target_nx = '0;
            w_wait_nx   = '0;
        end else if (w_mode == REP_CONSEC) begin
            w_state_nx  = REP_IDLE;
            w_hits_nx   = '0;
            w_target_nx = '0;
            w_wait_nx   = '0;
            if (i_ev) begin
                // >= so a lowered count mid-run still fires instead of running away.
                if (w_run_inc >= {1'b0, i_count}) begin
                    w_match_nx = 1'b1;
                    w_run_nx   = '0;
                end else begin
                    w_run_nx   = w_run_inc[CW-1:0];
                end
            end else begin
                w_run_nx = '0;
            end
        end else begin
            w_run_nx = '0;
            unique case (r_state)
                REP_IDLE: begin
                    if (i_start) begin
                        w_state_nx  = REP_ARMED;
                        w_target_nx = i_count;
                        w_hits_nx   = '0;
                        w_wait_nx   = '0;
                    end
                end
                REP_ARMED: begin
                    if (w_hit_done) begin
                        // Completion beats both expiry and a coincident restart.
                        w_match_nx = 1'b1;
                        w_hits_nx  = '0;
                        w_wait_nx  = '0;
                        if (i_start) begin
                            w_target_nx = i_count;
                        end else begin
                            w_state_nx = REP_IDLE;
                        end
                    end else if (i_start) begin
                        // Restart abandons the current window without a pulse.
                        w_target_nx = i_count;
                        w_hits_nx   = '0;
                        w_wait_nx   = '0;
                    end else if (w_expire) begin
                        w_timeout_nx = 1'b1;
                        w_state_nx   = REP_IDLE;
                        w_hits_nx    = '0;
                        w_wait_nx    = '0;
                    end else begin
                        if (i_ev) begin
                            w_hits_nx = w_hits_inc[CW-1:0];
                        end
                        w_wait_nx = w_wait_sat;
                    end
                end
                default: begin
                    w_state_nx = REP_IDLE;
                end
            endcase
        end
    end

    assign o_match   = r_match;
    assign o_timeout = r_timeout;
    assign o_busy    = (r_state == REP_ARMED);

endmodule

// File: rtl/repetition_matcher.sv
// Multi-channel repetition detector: one rep_channel per channel plus config slicing.
module repetition_matcher
    import rep_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int MAX_COUNT = 15,
    parameter int TW        = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_CH-1:0]                     ev,
    input  logic [NUM_CH-1:0]                     start,
    input  logic [NUM_CH-1:0]                     cfg_mode,
    input  logic [NUM_CH*rep_cw(MAX_COUNT)-1:0]   cfg_count,
    input  logic [TW-1:0]                         cfg_timeout,
    output logic [NUM_CH-1:0]                     match,
    output logic [NUM_CH-1:0]                     timeout,
    output logic [NUM_CH-1:0]                     busy
);

    localparam int CW = rep_cw(MAX_COUNT);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CW-1:0] w_count;

        assign w_count = cfg_count[gi*CW +: CW];

        rep_channel #(
            .CW (CW),
            .TW (TW)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_ev      (ev[gi]),
            .i_start   (start[gi]),
            .i_mode    (cfg_mode[gi]),
            .i_count   (w_count),
            .i_timeout (cfg_timeout),
            .o_match   (match[gi]),
            .o_timeout (timeout[gi]),
            .o_busy    (busy[gi])
        );
    end

endmodule

// File: tb/tb_repetition_matcher.sv
// Scoreboard bench for repetition_matcher (NUM_CH=4, MAX_COUNT=15, TW=8).
module tb_repetition_matcher;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ev;
    logic [3:0]  start;
    logic [3:0]  cfg_mode;
    logic [15:0] cfg_count;
    logic [7:0]  cfg_timeout;
    logic [3:0]  match;
    logic [3:0]  timeout;
    logic [3:0]  busy;

    repetition_matcher #(
        .NUM_CH    (4),
        .MAX_COUNT (15),
        .TW        (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ev          (ev),
        .start       (start),
        .cfg_mode    (cfg_mode),
        .cfg_count   (cfg_count),
        .cfg_timeout (cfg_timeout),
        .match       (match),
        .timeout     (timeout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] m;
        logic [3:0] t;
        bit         cb;
        logic [3:0] b;
    } sb_t;

    sb_t q[$];
    int  nvec = 0;
    int  nerr = 0;

    // Expected output for the cycle following posedge number c (merged per cycle).
    task automatic sb_push(input int c, input logic [3:0] m, input logic [3:0] t,
                           input bit cb, input logic [3:0] b);
        sb_t e;
        int  pos;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].cyc == c) begin
                e   = q[i];
                e.m = e.m | m;
                e.t = e.t | t;
                if (cb) begin
                    e.cb = 1'b1;
                    e.b  = b;
                end
                q[i] = e;
                return;
            end
        end
        e.cyc = c;
        e.m   = m;
        e.t   = t;
        e.cb  = cb;
        e.b   = b;
        pos   = q.size();
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc > c) pos = i;
        end
        q.insert(pos, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares DUT outputs against the scoreboard every cycle.
    always @(negedge clk) begin
        sb_t e;
        if (!rst_n) begin
            nvec++;
            if ((match | timeout | busy) !== 4'b0000) begin
                nerr++;
                $display("FAIL reset_state cyc=%0d got m=%b t=%b b=%b want all 0",
                         cyc, match, timeout, busy);
            end
        end else begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                nvec++;
                nerr++;
                $display("FAIL missed cyc=%0d want m=%b t=%b", e.cyc, e.m, e.t);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                nvec++;
                if (match !== e.m || timeout !== e.t || (e.cb && busy !== e.b)) begin
                    nerr++;
                    $display("FAIL pulse cyc=%0d got m=%b t=%b b=%b want m=%b t=%b b=%b(chk=%0d)",
                             cyc, match, timeout, busy, e.m, e.t, e.b, e.cb);
                end
            end else if ((match | timeout) !== 4'b0000) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected cyc=%0d got m=%b t=%b want none",
                         cyc, match, timeout);
            end
        end
    end

    logic [3:0] evt [8];
    logic [3:0] stt [8];
    logic [3:0] expm[8];
    logic [3:0] expt[8];
    logic [5:0] pat;

    initial begin
        rst_n       = 1'b0;
        ev          = '0;
        start       = '0;
        cfg_mode    = 4'b1100;
        cfg_count   = {4'd3, 4'd2, 4'd3, 4'd5};
        cfg_timeout = 8'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        tick();
        sb_push(cyc, 4'b0000, 4'b0000, 1'b1, 4'b0000);

        // CONSEC N=5 on ch0, 12 cycles of ev
        for (int i = 1; i <= 12; i++) begin
            ev = 4'b0001;
            if (i == 5 || i == 10) sb_push(cyc + 1, 4'b0001, 4'b0000, 1'b0, 4'b0000);
            tick();
        end
        ev = '0;
        tick();
        // run must have cleared: four more ones give no match
        for (int i = 1; i <= 4; i++) begin
            ev = 4'b0001;
            tick();
        end
        ev = '0;
        tick();

        // cfg_count = 0 disables ch0
        cfg_count[3:0] = 4'd0;
        for (int i = 1; i <= 6; i++) begin
            ev = 4'b0001;
            tick();
        end
        ev = '0;
        cfg_count[3:0] = 4'd5;
        tick();

        // CONSEC N=3 on ch1, pattern 1,1,0,1,1,1
        pat = 6'b111011;
        for (int i = 0; i < 6; i++) begin
            ev = {2'b00, pat[i], 1'b0};
            if (i == 5) sb_push(cyc + 1, 4'b0010, 4'b0000, 1'b0, 4'b0000);
            tick();
        end
        ev = '0;
        tick();

        // GOTO N=2 on ch2, no timeout, ev in start cycle ignored
        start = 4'b0100;
        ev    = 4'b0100;
        tick();
        start = '0;
        for (int k = 1; k <= 6; k++) begin
            ev = (k == 3 || k == 6) ? 4'b0100 : 4'b0000;
            sb_push(cyc, 4'b0000, 4'b0000, 1'b1, 4'b0100);
            if (k == 6) sb_push(cyc + 1, 4'b0100, 4'b0000, 1'b1, 4'b0000);
            tick();
        end
        ev = '0;
        tick();

        // GOTO N=3 on ch3, timeout 10, only two evs
        cfg_timeout = 8'd10;
        start = 4'b1000;
        tick();
        start = '0;
        for (int k = 1; k <= 10; k++) begin
            ev = (k == 2 || k == 5) ? 4'b1000 : 4'b0000;
            if (k == 10) sb_push(cyc + 1, 4'b0000, 4'b1000, 1'b1, 4'b0000);
            tick();
        end
        ev = '0;
        tick();
        // same, third ev on the expiry cycle: match wins
        start = 4'b1000;
        tick();
        start = '0;
        for (int k = 1; k <= 10; k++) begin
            ev = (k == 2 || k == 5 || k == 10) ? 4'b1000 : 4'b0000;
            if (k == 10) sb_push(cyc + 1, 4'b1000, 4'b0000, 1'b1, 4'b0000);
            tick();
        end
        ev = '0;
        cfg_timeout = 8'd0;
        tick();

        // GOTO restart on ch2, N=2, then match coinciding with start
        start = 4'b0100;
        tick();
        start = '0;
        ev    = 4'b0100;
        tick();
        start = 4'b0100;
        ev    = '0;
        tick();
        start = '0;
        ev    = 4'b0100;
        tick();
        ev    = '0;
        tick();
        ev    = 4'b0100;
        start = 4'b0100;
        sb_push(cyc + 1, 4'b0100, 4'b0000, 1'b1, 4'b0100);
        tick();
        start = '0;
        ev    = 4'b0100;
        tick();
        ev    = 4'b0100;
        sb_push(cyc + 1, 4'b0100, 4'b0000, 1'b1, 4'b0000);
        tick();
        ev = '0;
        tick();

        // mode change on an armed ch2 drops the window silently
        start = 4'b0100;
        tick();
        start = '0;
        tick();
        cfg_mode = 4'b1000;
        sb_push(cyc + 1, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        tick();
        cfg_mode = 4'b1100;
        tick();
        tick();

        // async reset mid-window: ch0 CONSEC run in progress, ch2 armed
        start = 4'b0100;
        ev    = 4'b0001;
        tick();
        start = '0;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        cfg_count   = {4'd1, 4'd3, 4'd4, 4'd2};
        cfg_timeout = 8'd6;
        tick();
        ev = '0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // four channels with independent configurations
        evt  = '{4'b0111, 4'b1011, 4'b0111, 4'b1011, 4'b0110, 4'b1011, 4'b0011, 4'b0010};
        stt  = '{4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        expm = '{4'b0000, 4'b1001, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
        expt = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
        for (int j = 0; j < 8; j++) begin
            ev    = evt[j];
            start = stt[j];
            if (j == 1) sb_push(cyc, 4'b0000, 4'b0000, 1'b1, 4'b1100);
            if ((expm[j] | expt[j]) != 4'b0000)
                sb_push(cyc + 1, expm[j], expt[j], 1'b0, 4'b0000);
            tick();
        end
        ev    = '0;
        start = '0;
        sb_push(cyc, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
